// File: rtl/xbuf_pkg.sv
// Shared sizing and types for the X operand ping-pong buffer.
// Pointer widths are derived so a matrix geometry change stays in one place.
package xbuf_pkg;

    localparam int DATA_W = 8;
    localparam int ROWS   = 8;
    localparam int COLS   = 4;
    localparam int PASSES = 4;

    localparam int ELEMS  = ROWS * COLS;
    localparam int SHIFTS = ROWS * PASSES;

    localparam int WP_W = $clog2(ELEMS);
    localparam int RR_W = $clog2(ROWS);
    localparam int SC_W = $clog2(SHIFTS);

    typedef logic [DATA_W-1:0] elem_t;
    typedef elem_t [COLS-1:0]  row_t;
    typedef logic [WP_W-1:0]   wptr_t;
    typedef logic [RR_W-1:0]   rrow_t;
    typedef logic [SC_W-1:0]   scnt_t;

    // Flat element address of (row, col) in row-major order.
    function automatic wptr_t elem_addr(input rrow_t row, input int col);
        return wptr_t'(int'(row) * COLS + col);
    endfunction

endpackage

// File: rtl/xbuf_bank.sv
// One X matrix bank: byte write port, full-row combinational read.
// Latency: write visible the cycle after we; read is zero-latency.
// Backpressure: none here; the owner decides when we may assert.
module xbuf_bank
    import xbuf_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  wptr_t waddr,
    input  elem_t wdata,
    input  rrow_t raddr,
    output row_t  rdata
);

    // Contents are intentionally not reset; full flags gate their use.
    elem_t mem [ELEMS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < COLS; c++) begin
            rdata[c] = mem[elem_addr(raddr, c)];
        end
    end

endmodule

// File: rtl/x_matrix_buffer.sv
// Ping-pong X operand buffer: byte-stream load, one row per X_shift to the MAC ALU.
// Latency: row visible the cycle after the last byte; X_reg* are a zero-latency mux.
// Backpressure: in_ready drops while the write bank is full; a release reopens it next cycle.
module x_matrix_buffer
    import xbuf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              X_shift,
    output logic [DATA_W-1:0] X_reg1,
    output logic [DATA_W-1:0] X_reg2,
    output logic [DATA_W-1:0] X_reg3,
    output logic [DATA_W-1:0] X_reg4,
    output logic              x_valid,
    output logic              bank_done,
    output logic              underrun
);

    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       wr_bank;
    logic       rd_bank;
    wptr_t      wr_ptr;
    rrow_t      rd_row;
    scnt_t      shift_cnt;

    logic       wr_fire;
    logic       wr_last;
    logic       shift_fire;
    logic       rel_fire;
    logic [1:0] bank_we;
    row_t       bank_row [2];
    row_t       cur_row;

    assign in_ready   = ~full[wr_bank];
    assign x_valid    = full[rd_bank];
    assign wr_fire    = in_valid & in_ready;
    assign wr_last    = wr_fire && (wr_ptr == wptr_t'(ELEMS - 1));
    assign shift_fire = X_shift & x_valid;
    assign rel_fire   = shift_fire && (shift_cnt == scnt_t'(SHIFTS - 1));

    assign bank_we[0] = wr_fire & ~wr_bank;
    assign bank_we[1] = wr_fire &  wr_bank;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        xbuf_bank u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (wr_ptr),
            .wdata (in_data),
            .raddr (rd_row),
            .rdata (bank_row[b])
        );
    end

    assign cur_row = rd_bank ? bank_row[1] : bank_row[0];

    always_comb begin
        X_reg1 = '0;
        X_reg2 = '0;
        X_reg3 = '0;
        X_reg4 = '0;
        if (x_valid) begin
            X_reg1 = cur_row[0];
            X_reg2 = cur_row[1];
            X_reg3 = cur_row[2];
            X_reg4 = cur_row[3];
        end
    end

    // A completing write and a release always target different banks: the
    // write bank is empty and the read bank is full, so both updates apply.
    always_comb begin
        full_nxt = full;
        if (wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rel_fire) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_ptr    <= '0;
            rd_row    <= '0;
            shift_cnt <= '0;
            bank_done <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            full      <= full_nxt;
            bank_done <= rel_fire;

            if (X_shift && !x_valid) begin
                underrun <= 1'b1;
            end

            if (wr_fire) begin
                if (wr_last) begin
                    wr_ptr  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end

            // Row wrap starts the next pass; only the shift count releases.
            if (shift_fire) begin
                if (rel_fire) begin
                    rd_row    <= '0;
                    shift_cnt <= '0;
                    rd_bank   <= ~rd_bank;
                end else begin
                    rd_row    <= (rd_row == rrow_t'(ROWS - 1)) ? '0 : rd_row + 1'b1;
                    shift_cnt <= shift_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_x_matrix_buffer.sv
// Directed self-checking bench for x_matrix_buffer.
module tb_x_matrix_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       X_shift = 1'b0;
    logic [7:0] X_reg1, X_reg2, X_reg3, X_reg4;
    logic       x_valid;
    logic       bank_done;
    logic       underrun;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    x_matrix_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X_shift   (X_shift),
        .X_reg1    (X_reg1),
        .X_reg2    (X_reg2),
        .X_reg3    (X_reg3),
        .X_reg4    (X_reg4),
        .x_valid   (x_valid),
        .bank_done (bank_done),
        .underrun  (underrun)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected row: four consecutive bytes starting at first.
    task automatic check_row(input string tag, input logic [7:0] first);
        logic [7:0] v;
        v = first;
        chk8({tag, "_x1"}, X_reg1, v);
        v = v + 8'd1;
        chk8({tag, "_x2"}, X_reg2, v);
        v = v + 8'd1;
        chk8({tag, "_x3"}, X_reg3, v);
        v = v + 8'd1;
        chk8({tag, "_x4"}, X_reg4, v);
    endtask

    // Streams base..base+31; xv is the x_valid expected throughout the load.
    task automatic load_mat(input logic [7:0] base, input logic xv);
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            chk1("load_rdy", in_ready, 1'b1);
            chk1("load_xv", x_valid, xv);
            tick;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // n shifts of a bank loaded from base; no release pulse expected inside.
    task automatic shift_chk(input logic [7:0] base, input int n);
        for (int s = 0; s < n; s++) begin
            X_shift = 1'b1;
            check_row("shift_row", base + 8'(4 * (s % 8)));
            chk1("shift_xv", x_valid, 1'b1);
            chk1("shift_done_quiet", bank_done, 1'b0);
            tick;
        end
        X_shift = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        tick;
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        tick;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_x_valid", x_valid, 1'b0);
        chk8("rst_x1", X_reg1, 8'h00);
        chk8("rst_x4", X_reg4, 8'h00);
        chk1("rst_done", bank_done, 1'b0);
        chk1("rst_underrun", underrun, 1'b0);
        rst = 1'b1;
        tick;

        // Single matrix load, then full consumption
        load_mat(8'h01, 1'b0);
        chk1("load1_xv", x_valid, 1'b1);
        chk1("load1_rdy_other", in_ready, 1'b1);
        check_row("load1_row0", 8'h01);
        shift_chk(8'h01, 32);
        chk1("rel1_done", bank_done, 1'b1);
        chk1("rel1_xv", x_valid, 1'b0);
        chk8("rel1_x1", X_reg1, 8'h00);
        tick;
        chk1("rel1_done_pulse", bank_done, 1'b0);
        chk1("rel1_rdy", in_ready, 1'b1);

        // Back-to-back: B streams in while A is consumed
        load_mat(8'h01, 1'b0);
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h41 + 8'(i);
            X_shift  = 1'b1;
            chk1("b2b_rdy", in_ready, 1'b1);
            chk1("b2b_xv", x_valid, 1'b1);
            check_row("b2b_row", 8'h01 + 8'(4 * (i % 8)));
            tick;
        end
        in_valid = 1'b0;
        X_shift  = 1'b0;
        chk1("b2b_done", bank_done, 1'b1);
        chk1("b2b_xv_next", x_valid, 1'b1);
        check_row("b2b_B_row0", 8'h41);
        chk1("b2b_rdy_after", in_ready, 1'b1);
        tick;
        chk1("b2b_done_pulse", bank_done, 1'b0);
        do_reset;

        // Three matrices, no shifts: third stalls until a release
        load_mat(8'h01, 1'b0);
        load_mat(8'h21, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hC1;
        for (int i = 0; i < 3; i++) begin
            chk1("full_stall_rdy", in_ready, 1'b0);
            tick;
        end
        chk1("full_xv", x_valid, 1'b1);
        for (int s = 0; s < 32; s++) begin
            X_shift = 1'b1;
            chk1("full_shift_rdy", in_ready, 1'b0);
            check_row("full_shift_row", 8'h01 + 8'(4 * (s % 8)));
            tick;
        end
        X_shift = 1'b0;
        chk1("reopen_rdy", in_ready, 1'b1);
        chk1("reopen_done", bank_done, 1'b1);
        check_row("reopen_bank1_row0", 8'h21);
        load_mat(8'hC1, 1'b1);
        chk1("third_full_rdy", in_ready, 1'b0);
        shift_chk(8'h21, 32);
        chk1("third_done", bank_done, 1'b1);
        chk1("third_xv", x_valid, 1'b1);
        check_row("third_row0", 8'hC1);
        do_reset;

        // Underrun with both banks empty
        X_shift = 1'b1;
        chk1("und_before", underrun, 1'b0);
        chk8("und_x1", X_reg1, 8'h00);
        chk8("und_x3", X_reg3, 8'h00);
        tick;
        X_shift = 1'b0;
        chk1("und_set", underrun, 1'b1);
        chk1("und_xv", x_valid, 1'b0);
        tick;
        chk1("und_sticky", underrun, 1'b1);
        load_mat(8'h01, 1'b0);
        check_row("und_row0", 8'h01);
        shift_chk(8'h01, 32);
        chk1("und_rel_done", bank_done, 1'b1);
        chk1("und_sticky2", underrun, 1'b1);

        // Reset mid-load and mid-consumption
        load_mat(8'h01, 1'b0);
        shift_chk(8'h01, 5);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h90 + 8'(i);
            chk1("part_rdy", in_ready, 1'b1);
            tick;
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk1("mid_rst_rdy", in_ready, 1'b1);
        chk1("mid_rst_xv", x_valid, 1'b0);
        chk8("mid_rst_x1", X_reg1, 8'h00);
        chk1("mid_rst_und", underrun, 1'b0);
        chk1("mid_rst_done", bank_done, 1'b0);
        tick;
        rst = 1'b1;
        tick;
        chk1("post_rst_done", bank_done, 1'b0);
        load_mat(8'h51, 1'b0);
        check_row("post_rst_row0", 8'h51);
        shift_chk(8'h51, 32);
        chk1("post_rst_rel", bank_done, 1'b1);
        chk1("post_rst_xv", x_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
